pit_lookup: RTL
===============

Name: pit_lookup

Overview:
- Pending Interest Table lookup and bookkeeping stage. Sits directly upstream of the PIT memory-streaming controller and produces the 12-bit table entry it consumes.
- Holds ENTRIES name records. For each request it searches by name, then inserts, marks received, or releases the record.
- Returns the entry word {received, requested, slot address} with a one-cycle response strobe.

Parameters:
- ENTRIES, 8, number of table records (power of two, ≥2)
- NAME_W, 16, width of the packet name key
- ADDR_W, 10, width of the memory slot address field

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  2  operation: 00 INTEREST, 01 DATA, 10 RELEASE, 11 reserved
- req_name  in  NAME_W  name key
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  name found in table
- resp_full  out  1  INTEREST miss with no free record
- table_entry  out  12  bit11 received, bit10 requested, bits9:0 slot address
- occupancy  out  $clog2(ENTRIES+1)  count of valid records

Behaviour:
- Reset values: every record valid=0; req_ready=1; resp_valid, resp_hit, resp_full=0; table_entry=0; occupancy=0; state IDLE.
- Record contents: valid, name, received, requested. Slot address of index i = i << (ADDR_W − log2(ENTRIES)); for the defaults this is i*128.
- IDLE:
  - On req_valid && req_ready, latch op and name, drop req_ready, go to SEARCH.
- SEARCH:
  - Scan one index per cycle, 0 to ENTRIES−1, always a full scan.
  - Record the lowest matching valid index (hit) and the lowest invalid index (free).
  - Then go to UPDATE.
- UPDATE (one cycle): apply the table change, load the response registers, set resp_valid=1, go to RESPOND.
  - INTEREST hit: set requested=1. table_entry = {received, 1, addr}. resp_hit=1.
  - INTEREST miss with a free record: write valid=1, name, received=0, requested=1. table_entry = {0, 1, addr}. resp_hit=0. occupancy+1.
  - INTEREST miss with no free record: no table change. resp_full=1. table_entry=0.
  - DATA hit: set received=1. table_entry = {1, requested, addr}. resp_hit=1.
  - DATA miss: no change. resp_hit=0. table_entry=0 (unsolicited data dropped).
  - RELEASE hit: clear valid. resp_hit=1. table_entry = the entry value before clearing. occupancy−1.
  - RELEASE miss: no change. resp_hit=0. table_entry=0.
  - Reserved op: no change. All response fields 0 except resp_valid.
- RESPOND:
  - resp_valid is high for exactly this cycle.
  - Next edge: resp_valid=0, req_ready=1, go to IDLE.
  - resp_hit, resp_full and table_entry hold their values until the next UPDATE.
- Latency: resp_valid is high in the cycle following the (ENTRIES+1)th edge after the accepting edge. req_ready is low for ENTRIES+2 cycles. Throughput is one request per ENTRIES+3 cycles.
- Name uniqueness: duplicate names cannot arise, because insertion happens only on a miss. Lowest index wins regardless.
- Occupancy is always ≤ ENTRIES, with no wrap. Saturation is reported through resp_full.
- Reset asserted mid-operation: abort immediately, clear all records, suppress any pending response, return to reset values.
- req_valid while req_ready=0 is ignored. The requester must hold req_valid, req_op and req_name stable until it is accepted.

Decomposition:
- Shared package pit_pkg:
  - op encodings OP_INTEREST, OP_DATA, OP_RELEASE
  - RECEIVED_BIT=11, REQUESTED_BIT=10, ADDR_MSB=9, ADDR_LSB=0
  - FSM state encodings IDLE, SEARCH, UPDATE, RESPOND
- Single module. Record storage is a register array with the scan comparator inline; no sub-module is needed.

Test Plan:
1. Reset, then INTEREST 0xABCD -> resp_valid 10 cycles after accept; hit=0, full=0, table_entry=12'h400; occupancy=1.
2. DATA 0xABCD, then INTEREST 0xABCD -> both responses hit=1, table_entry=12'hC00; occupancy stays 1.
3. After reset, INTERESTs for 0x0001..0x0008 -> entries 12'h400, 12'h480, ..., 12'h780; a ninth INTEREST 0x0009 -> full=1, table_entry=0, occupancy=8.
4. From state 3, RELEASE 0x0003 -> hit=1, table_entry=12'h500, occupancy=7. Then INTEREST 0x0009 -> hit=0, table_entry=12'h500, occupancy=8.
5. DATA 0x7777 (absent) and reserved op 11 -> hit=0, table_entry=0, no occupancy change. A later INTEREST 0x7777 misses and inserts.
6. Assert reset during SEARCH -> no resp_valid pulse, req_ready=1 and occupancy=0 after release of reset. A following INTEREST for a previously inserted name returns hit=0, table_entry=12'h400.

Source files
------------

// File: rtl/pit_pkg.sv
// Shared encodings for the Pending Interest Table lookup stage.
package pit_pkg;

    typedef enum logic [1:0] {
        OP_INTEREST = 2'b00,
        OP_DATA     = 2'b01,
        OP_RELEASE  = 2'b10,
        OP_RESERVED = 2'b11
    } pit_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEARCH  = 2'b01,
        UPDATE  = 2'b10,
        RESPOND = 2'b11
    } pit_state_e;

    localparam int unsigned RECEIVED_BIT  = 11;
    localparam int unsigned REQUESTED_BIT = 10;
    localparam int unsigned ADDR_MSB      = 9;
    localparam int unsigned ADDR_LSB      = 0;

endpackage

// File: rtl/pit_lookup.sv
// PIT lookup: sequential name search over ENTRIES records, then insert/mark/release
// and return the {received, requested, slot address} entry word.
module pit_lookup
    import pit_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned NAME_W  = 16,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [1:0]                         req_op,
    input  logic [NAME_W-1:0]                  req_name,
    output logic                               resp_valid,
    output logic                               resp_hit,
    output logic                               resp_full,
    output logic [11:0]                        table_entry,
    output logic [$clog2(ENTRIES+1)-1:0]       occupancy
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = $clog2(ENTRIES+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    pit_state_e r_state, w_state_next;

    logic              r_valid [ENTRIES];
    logic [NAME_W-1:0] r_name  [ENTRIES];
    logic              r_rcvd  [ENTRIES];
    logic              r_reqd  [ENTRIES];

    pit_op_e           r_op;
    logic [NAME_W-1:0] r_key;
    logic [IDX_W-1:0]  r_idx;
    logic              r_hit_found, r_free_found;
    logic [IDX_W-1:0]  r_hit_idx, r_free_idx;

    logic              r_resp_hit, r_resp_full;
    logic [11:0]       r_entry;
    logic [OCC_W-1:0]  r_occ;

    logic [ADDR_W-1:0] w_hit_addr, w_free_addr;

    assign w_hit_addr  = ADDR_W'(r_hit_idx) << (ADDR_W - IDX_W);
    assign w_free_addr = ADDR_W'(r_free_idx) << (ADDR_W - IDX_W);

    function automatic logic [11:0] mk_entry(logic rcv, logic req, logic [ADDR_W-1:0] addr);
        logic [11:0] e;
        e = '0;
        e[RECEIVED_BIT]      = rcv;
        e[REQUESTED_BIT]     = req;
        e[ADDR_MSB:ADDR_LSB] = addr[ADDR_MSB:ADDR_LSB];
        return e;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = SEARCH;
            end
            SEARCH:  if (r_idx == LAST_IDX) w_state_next = UPDATE;
            UPDATE:  w_state_next = RESPOND;
            RESPOND: begin
                resp_valid   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_name[i]  <= '0;
                r_rcvd[i]  <= 1'b0;
                r_reqd[i]  <= 1'b0;
            end
            r_op         <= OP_INTEREST;
            r_key        <= '0;
            r_idx        <= '0;
            r_hit_found  <= 1'b0;
            r_free_found <= 1'b0;
            r_hit_idx    <= '0;
            r_free_idx   <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_full  <= 1'b0;
            r_entry      <= '0;
            r_occ        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op         <= pit_op_e'(req_op);
                        r_key        <= req_name;
                        r_idx        <= '0;
                        r_hit_found  <= 1'b0;
                        r_free_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    // First match latched sticks, so the lowest index wins.
                    if (r_valid[r_idx] && (r_name[r_idx] == r_key) && !r_hit_found) begin
                        r_hit_found <= 1'b1;
                        r_hit_idx   <= r_idx;
                    end
                    if (!r_valid[r_idx] && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    r_idx <= r_idx + IDX_W'(1);
                end
                UPDATE: begin
                    r_resp_hit  <= 1'b0;
                    r_resp_full <= 1'b0;
                    r_entry     <= '0;
                    unique case (r_op)
                        OP_INTEREST: begin
                            if (r_hit_found) begin
                                r_reqd[r_hit_idx] <= 1'b1;
                                r_resp_hit        <= 1'b1;
                                r_entry <= mk_entry(r_rcvd[r_hit_idx], 1'b1, w_hit_addr);
                            end else if (r_free_found) begin
                                r_valid[r_free_idx] <= 1'b1;
                                r_name[r_free_idx]  <= r_key;
                                r_rcvd[r_free_idx]  <= 1'b0;
                                r_reqd[r_free_idx]  <= 1'b1;
                                r_entry <= mk_entry(1'b0, 1'b1, w_free_addr);
                                r_occ   <= r_occ + OCC_W'(1);
                            end else begin
                                r_resp_full <= 1'b1;
                            end
                        end
                        OP_DATA: begin
                            if (r_hit_found) begin
                                r_rcvd[r_hit_idx] <= 1'b1;
                                r_resp_hit        <= 1'b1;
                                r_entry <= mk_entry(1'b1, r_reqd[r_hit_idx], w_hit_addr);
                            end
                        end
                        OP_RELEASE: begin
                            if (r_hit_found) begin
                                r_valid[r_hit_idx] <= 1'b0;
                                r_resp_hit         <= 1'b1;
                                r_entry <= mk_entry(r_rcvd[r_hit_idx], r_reqd[r_hit_idx],
                                                    w_hit_addr);
                                r_occ   <= r_occ - OCC_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign resp_hit    = r_resp_hit;
    assign resp_full   = r_resp_full;
    assign table_entry = r_entry;
    assign occupancy   = r_occ;

endmodule
